// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control FSM: sequences fetch/decode/execute/memory/writeback strobes.
// Latency: 2..5 cycles per instruction with mem_ready=1 (memory states stretch while it is low).
// Backpressure: FETCH, MEMRD and MEMWR hold until mem_ready; other states always advance.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   instr[31:0]       instruction register contents (stable from DECODE onward)
//   flags[3:0]        NZCV condition flags (bit3=N, bit2=Z, bit1=C, bit0=V)
//   mem_ready         memory access completes this cycle
//   pc_write, ir_write, adr_src, reg_write, mem_write, alu_src_a,
//   flag_write, shift_enable, reg_src       datapath strobes / selects
//   alu_src_b[1:0]    00 register, 01 immediate, 10 constant 4
//   result_src[1:0]   00 ALUOut, 01 data register, 10 ALU direct, 11 shifter register
//   alu_control[2:0]  000 add, 001 sub, 010 cmp, 100 and, 101 orr
//   state[3:0]        current FSM state encoding
//   instr_done        one-cycle pulse in the last state of every instruction
//   illegal           one-cycle pulse when DECODE sees an unsupported encoding
module multicycle_controller #(
    parameter int COND_EXEC     = 1,
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [3:0]  flags,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        adr_src,
    output logic        reg_write,
    output logic        mem_write,
    output logic        alu_src_a,
    output logic        flag_write,
    output logic        shift_enable,
    output logic        reg_src,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [2:0]  alu_control,
    output logic [3:0]  state,
    output logic        instr_done,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECS  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    // Instruction classes recognised by the decoder.
    typedef enum logic [3:0] {
        C_ADD,
        C_SUB,
        C_AND,
        C_ORR,
        C_CMP,
        C_LSL,
        C_LSR,
        C_LDR,
        C_STR,
        C_B,
        C_ILL
    } cls_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_CMP = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_ORR = 3'b101;

    state_t     state_q;
    state_t     state_nxt;
    cls_t       cls;
    logic       mem_rdy;
    logic       cond_ok;
    logic       is_shift;
    logic [1:0] op;
    logic [3:0] cmd;

    // Fields the decoder never looks at (I bit, register numbers, Rm).
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[25], instr[19:12], instr[3:0]};

    assign op  = instr[27:26];
    assign cmd = instr[24:21];

    // With the handshake disabled every memory access is assumed single-cycle.
    assign mem_rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    // Standard ARM condition table; 1111 never executes.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n;
        logic z;
        logic cf;
        logic v;
        logic r;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c)
            4'b0000: r = z;
            4'b0001: r = !z;
            4'b0010: r = cf;
            4'b0011: r = !cf;
            4'b0100: r = n;
            4'b0101: r = !n;
            4'b0110: r = v;
            4'b0111: r = !v;
            4'b1000: r = cf && !z;
            4'b1001: r = !cf || z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = !z && (n == v);
            4'b1101: r = z || (n != v);
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign cond_ok = (COND_EXEC != 0) ? cond_pass(instr[31:28], flags) : 1'b1;

    // Instruction class decode. cmd 1101 is MOV in ARM; only its shifted
    // register forms are supported, and LSL #0 (a plain MOV) is rejected.
    always_comb begin
        cls = C_ILL;
        case (op)
            2'b00: begin
                case (cmd)
                    4'b0100: cls = C_ADD;
                    4'b0010: cls = C_SUB;
                    4'b0000: cls = C_AND;
                    4'b1100: cls = C_ORR;
                    4'b1010: cls = C_CMP;
                    4'b1101: begin
                        if (instr[6:5] == 2'b00 && instr[11:4] != 8'd0) begin
                            cls = C_LSL;
                        end else if (instr[6:5] == 2'b01) begin
                            cls = C_LSR;
                        end else begin
                            cls = C_ILL;
                        end
                    end
                    default: cls = C_ILL;
                endcase
            end
            2'b01: begin
                cls = instr[20] ? C_LDR : C_STR;
            end
            2'b10: begin
                cls = instr[24] ? C_ILL : C_B;
            end
            default: cls = C_ILL;
        endcase
    end

    assign is_shift = (cls == C_LSL) || (cls == C_LSR);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_nxt;
        end
    end

    assign state = state_q;

    // Next state and outputs. Every output is forced to its idle value while
    // rst_n is low so nothing leaks out of FETCH during reset.
    always_comb begin
        state_nxt    = state_q;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        adr_src      = 1'b0;
        reg_write    = 1'b0;
        mem_write    = 1'b0;
        alu_src_a    = 1'b0;
        flag_write   = 1'b0;
        shift_enable = 1'b0;
        reg_src      = 1'b0;
        alu_src_b    = 2'b00;
        result_src   = 2'b00;
        alu_control  = ALU_ADD;
        instr_done   = 1'b0;
        illegal      = 1'b0;

        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    // PC + 4 computed on the ALU and written back directly.
                    alu_src_a   = 1'b1;
                    alu_src_b   = 2'b10;
                    alu_control = ALU_ADD;
                    result_src  = 2'b10;
                    ir_write    = mem_rdy;
                    pc_write    = mem_rdy;
                    state_nxt   = mem_rdy ? S_DECODE : S_FETCH;
                end

                S_DECODE: begin
                    illegal = (cls == C_ILL);
                    if (!cond_ok || cls == C_ILL) begin
                        // Squashed instruction: retire with no writes.
                        instr_done = 1'b1;
                        state_nxt  = S_FETCH;
                    end else begin
                        case (cls)
                            C_LDR, C_STR:                      state_nxt = S_MEMADR;
                            C_ADD, C_SUB, C_AND, C_ORR, C_CMP: state_nxt = S_EXECR;
                            C_LSL, C_LSR:                      state_nxt = S_EXECS;
                            C_B:                               state_nxt = S_BRANCH;
                            default:                           state_nxt = S_FETCH;
                        endcase
                    end
                end

                S_MEMADR: begin
                    alu_src_b   = 2'b01;
                    alu_control = ALU_ADD;
                    // STR needs Rd on the second read port to supply store data.
                    reg_src     = (cls == C_STR);
                    state_nxt   = (cls == C_STR) ? S_MEMWR : S_MEMRD;
                end

                S_MEMRD: begin
                    adr_src   = 1'b1;
                    state_nxt = mem_rdy ? S_MEMWB : S_MEMRD;
                end

                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end

                S_MEMWR: begin
                    // Write is held asserted until memory accepts it.
                    adr_src   = 1'b1;
                    reg_src   = 1'b1;
                    mem_write = 1'b1;
                    if (mem_rdy) begin
                        instr_done = 1'b1;
                        state_nxt  = S_FETCH;
                    end
                end

                S_EXECR: begin
                    alu_src_b = 2'b00;
                    case (cls)
                        C_SUB:   alu_control = ALU_SUB;
                        C_CMP:   alu_control = ALU_CMP;
                        C_AND:   alu_control = ALU_AND;
                        C_ORR:   alu_control = ALU_ORR;
                        default: alu_control = ALU_ADD;
                    endcase
                    if (cls == C_CMP) begin
                        // CMP only updates flags; it has no writeback cycle.
                        flag_write = 1'b1;
                        reg_src    = 1'b1;
                        instr_done = 1'b1;
                        state_nxt  = S_FETCH;
                    end else begin
                        state_nxt = S_ALUWB;
                    end
                end

                S_EXECS: begin
                    shift_enable = 1'b1;
                    state_nxt    = S_ALUWB;
                end

                S_ALUWB: begin
                    reg_write  = 1'b1;
                    result_src = is_shift ? 2'b11 : 2'b00;
                    instr_done = 1'b1;
                    state_nxt  = S_FETCH;
                end

                S_BRANCH: begin
                    alu_src_b   = 2'b01;
                    alu_control = ALU_ADD;
                    result_src  = 2'b10;
                    pc_write    = 1'b1;
                    instr_done  = 1'b1;
                    state_nxt   = S_FETCH;
                end

                default: begin
                    // Unused encodings recover to FETCH with all strobes idle.
                    state_nxt = S_FETCH;
                end
            endcase
        end
    end

endmodule
